// File: rtl/data_mem_mmio.sv
// ---------------------------------------------------------------------------
// data_mem_mmio
//
// Data-side memory responder for a single-cycle CPU with no stall input.
// Loads are combinational and stores commit at the rising edge. The block
// holds three things:
//   * a word-addressed data RAM at byte addresses [0, RAM_WORDS*4);
//   * a free-running 32-bit cycle counter (CYCLE, MMIO_BASE+0x0);
//   * a transmit FIFO that is pushed by stores to TXDATA (MMIO_BASE+0x4) and
//     drained through a valid/ready handshake. STATUS (MMIO_BASE+0x8) reports
//     empty, full, sticky overflow and the occupancy count.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   Addres     CPU data byte address (bits [1:0] ignored)
//   WriteData  CPU store data
//   MemWrite   store strobe
//   readData   load data, combinational from Addres
//   tx_data    head entry of the TX FIFO
//   tx_valid   FIFO non-empty (forced low while rst is high)
//   tx_ready   consumer accepts the head entry this cycle
// ---------------------------------------------------------------------------
module data_mem_mmio #(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addres,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] readData,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int          RAM_AW     = $clog2(RAM_WORDS);
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam int          CW         = PW + 1;
    localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
    localparam logic [31:0] CYCLE_ADDR = MMIO_BASE;
    localparam logic [31:0] TX_ADDR    = MMIO_BASE + 32'h4;
    localparam logic [31:0] STAT_ADDR  = MMIO_BASE + 32'h8;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    // Storage arrays (no reset; RAM contents survive rst)
    logic [31:0] ram_mem  [RAM_WORDS];
    logic [31:0] fifo_mem [FIFO_DEPTH];

    // Registered state
    logic [31:0]   cycle_q,  cycle_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;

    // Decode and control
    logic [31:0]       word_addr;
    logic              sel_ram, sel_cycle, sel_tx, sel_stat;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_en, fifo_empty, fifo_full, pop;
    logic              push_req, push_ok, ovf_set, ovf_clr;
    logic [31:0]       status_word;

    // Masking keeps the byte offset out of every region compare.
    assign word_addr = Addres & 32'hFFFF_FFFC;
    assign sel_ram   = (word_addr < RAM_BYTES);
    assign sel_cycle = (word_addr == CYCLE_ADDR);
    assign sel_tx    = (word_addr == TX_ADDR);
    assign sel_stat  = (word_addr == STAT_ADDR);
    assign ram_idx   = Addres[RAM_AW+1:2];

    always_comb begin
        wr_en       = MemWrite && !rst;
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == DEPTH_C);
        // tx_valid depends only on registered state and rst, never on tx_ready.
        tx_valid    = !rst && !fifo_empty;
        tx_data     = fifo_mem[rd_ptr_q];
        pop         = tx_valid && tx_ready;

        push_req    = wr_en && sel_tx;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok     = push_req && (!fifo_full || pop);
        ovf_set     = push_req && fifo_full && !pop;
        ovf_clr     = wr_en && sel_stat && WriteData[2];

        cycle_d     = cycle_q + 32'd1;
        wr_ptr_d    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push_ok) - CW'(pop);

        // Set has priority over a simultaneous clear.
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        status_word = {16'h0000, 8'(count_q), 5'b00000, ovf_q, fifo_full, fifo_empty};

        readData = 32'h0;
        if (!rst) begin
            if (sel_ram) begin
                readData = ram_mem[ram_idx];
            end else if (sel_cycle) begin
                readData = cycle_q;
            end else if (sel_stat) begin
                readData = status_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && sel_ram) begin
            ram_mem[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= WriteData;
        end
    end

endmodule
